// File: rtl/phit_send.sv
// phit_send: serialises a flit of flit_size phits onto a phit_size-wide link.
// Phit 0 (low bits) is sent first; each phit is consumed when new_phit & en.
// A new flit may be loaded in the same cycle the final phit is consumed, so
// back-to-back flits leave no idle gap on the link.
module phit_send #(
    parameter int unsigned flit_size                   = 1,
    parameter int unsigned floorplusone_log2_flit_size = 1,
    parameter int unsigned phit_size                   = 16
) (
    input  logic                           clk,
    input  logic                           rs,
    input  logic [flit_size*phit_size-1:0] indata,
    input  logic                           invalid,
    output logic                           inready,
    output logic [phit_size-1:0]           outdata,
    output logic                           new_phit,
    input  logic                           en,
    output logic                           last
);

    localparam int unsigned PtrW = floorplusone_log2_flit_size;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(flit_size - 1);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e                         state_q, state_d;
    logic [PtrW-1:0]                ptr_q, ptr_d;
    logic [flit_size*phit_size-1:0] flit_q, flit_d;

    logic at_last;
    logic consume;
    logic load;

    // Outputs, handshake and next-state decode.
    always_comb begin
        new_phit = (state_q == StSend);
        at_last  = (ptr_q == LastPtr);
        last     = new_phit & at_last;
        consume  = new_phit & en;
        inready  = (state_q == StIdle) | (en & last);
        load     = invalid & inready;

        // Link is driven to zero whenever no phit is being presented.
        outdata = '0;
        if (new_phit) begin
            for (int unsigned k = 0; k < flit_size; k++) begin
                if (ptr_q == PtrW'(k)) begin
                    outdata = flit_q[k*phit_size +: phit_size];
                end
            end
        end

        state_d = state_q;
        ptr_d   = ptr_q;
        flit_d  = flit_q;
        // A load always restarts at phit 0; it only happens when idle or when
        // the last phit is leaving, so it never overwrites a flit in flight.
        if (load) begin
            state_d = StSend;
            ptr_d   = '0;
            flit_d  = indata;
        end else if (consume) begin
            if (at_last) begin
                state_d = StIdle;
                ptr_d   = '0;
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end
    end

    // State, pointer and flit registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rs) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            flit_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            flit_q  <= flit_d;
        end
    end

endmodule

// File: tb/tb_phit_send.sv
// tb_phit_send: directed and randomised checks of phit_send against a
// queue-based model of the link plus a behavioural phit receiver.
module tb_phit_send;

    localparam int unsigned FS = 4;
    localparam int unsigned PS = 16;

    logic        clk = 1'b0;
    logic        rs;
    logic [63:0] indata;
    logic        invalid;
    logic        inready;
    logic [15:0] outdata;
    logic        new_phit;
    logic        en;
    logic        last;

    logic [15:0] indata1;
    logic        invalid1;
    logic        inready1;
    logic [15:0] outdata1;
    logic        new_phit1;
    logic        en1;
    logic        last1;

    always #5 clk = ~clk;

    phit_send #(
        .flit_size                   (FS),
        .floorplusone_log2_flit_size (3),
        .phit_size                   (PS)
    ) u_dut (
        .clk      (clk),
        .rs       (rs),
        .indata   (indata),
        .invalid  (invalid),
        .inready  (inready),
        .outdata  (outdata),
        .new_phit (new_phit),
        .en       (en),
        .last     (last)
    );

    phit_send #(
        .flit_size                   (1),
        .floorplusone_log2_flit_size (1),
        .phit_size                   (PS)
    ) u_dut1 (
        .clk      (clk),
        .rs       (rs),
        .indata   (indata1),
        .invalid  (invalid1),
        .inready  (inready1),
        .outdata  (outdata1),
        .new_phit (new_phit1),
        .en       (en1),
        .last     (last1)
    );

    int checks = 0;
    int errors = 0;

    // Model: phits still to appear on the link, flits awaiting reception.
    logic [15:0] q[$];
    logic [63:0] sent[$];
    logic [63:0] rx_acc;
    int          rx_cnt  = 0;
    int          acc_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare link outputs to the model, clock once, then advance the model.
    task automatic tick();
        logic rdy;
        logic [63:0] flit;
        #1;
        rdy = (q.size() == 0) || (en && q.size() == 1);
        check("new", new_phit, q.size() != 0);
        check("outdata", outdata, (q.size() != 0) ? q[0] : 16'h0);
        check("last", last, q.size() == 1);
        check("inready", inready, rdy);
        // Receiver: assemble consumed phits low-first.
        if (q.size() != 0 && en) begin
            rx_acc[rx_cnt*16 +: 16] = outdata;
            rx_cnt++;
            if (rx_cnt == FS) begin
                flit = (sent.size() != 0) ? sent.pop_front() : 64'hx;
                check("rx_flit", rx_acc, flit);
                rx_cnt = 0;
            end
        end
        @(posedge clk);
        if (rs) begin
            q.delete();
            sent.delete();
            rx_cnt = 0;
        end else begin
            if (q.size() != 0 && en) void'(q.pop_front());
            if (invalid && rdy) begin
                for (int k = 0; k < FS; k++) q.push_back(indata[k*16 +: 16]);
                sent.push_back(indata);
                acc_cnt++;
            end
        end
        @(negedge clk);
    endtask

    task automatic expect_phit(input string tag, input logic [15:0] d, input logic l);
        #1;
        check(tag, outdata, d);
        check({tag, "_last"}, last, l);
        check({tag, "_new"}, new_phit, 1'b1);
    endtask

    logic [63:0] flit_a = 64'h4444_3333_2222_1111;
    logic [63:0] flit_b = 64'h8888_7777_6666_5555;
    logic [15:0] prev1;

    initial begin
        rs = 1'b1; invalid = 1'b0; en = 1'b0; indata = '0;
        invalid1 = 1'b0; en1 = 1'b0; indata1 = '0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        rs = 1'b0;
        #1;
        check("rst_new", new_phit, 1'b0);
        check("rst_out", outdata, 16'h0);
        check("rst_last", last, 1'b0);
        check("rst_rdy", inready, 1'b1);
        @(negedge clk);

        // Basic send.
        indata = flit_a; invalid = 1'b1; en = 1'b1;
        tick();
        invalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_phit("basic", flit_a[i*16 +: 16], i == 3);
            tick();
        end
        #1;
        check("basic_idle_new", new_phit, 1'b0);
        check("basic_idle_out", outdata, 16'h0);

        // Stall on the second phit; an offer during the stall must be ignored.
        @(negedge clk);
        indata = flit_a; invalid = 1'b1;
        tick();
        invalid = 1'b0;
        tick();
        en = 1'b0; indata = flit_b; invalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_phit("stall", 16'h2222, 1'b0);
            check("stall_rdy", inready, 1'b0);
            tick();
        end
        invalid = 1'b0; en = 1'b1;
        expect_phit("stall_resume", 16'h2222, 1'b0);
        tick();
        expect_phit("stall_resume", 16'h3333, 1'b0);
        tick();
        expect_phit("stall_resume", 16'h4444, 1'b1);
        tick();

        // Back-to-back flits.
        indata = flit_a; invalid = 1'b1;
        tick();
        indata = flit_b;
        for (int i = 0; i < 4; i++) begin
            expect_phit("b2b_a", flit_a[i*16 +: 16], i == 3);
            check("b2b_rdy", inready, i == 3);
            tick();
        end
        invalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_phit("b2b_b", flit_b[i*16 +: 16], i == 3);
            tick();
        end

        // Reset while the third phit is on the link with a flit offered.
        indata = flit_a; invalid = 1'b1;
        tick();
        invalid = 1'b0;
        tick();
        tick();
        expect_phit("mid_pre", 16'h3333, 1'b0);
        indata = flit_b; invalid = 1'b1; rs = 1'b1;
        tick();
        rs = 1'b0; invalid = 1'b0;
        #1;
        check("mid_new", new_phit, 1'b0);
        check("mid_out", outdata, 16'h0);
        check("mid_rdy", inready, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 3; i++) tick();

        // Randomised traffic with en gaps through the receiver model.
        acc_cnt = 0;
        for (int c = 0; c < 600 && acc_cnt < 16; c++) begin
            en      = ($urandom_range(0, 3) != 0);
            invalid = ($urandom_range(0, 2) != 0);
            indata  = {$urandom(), $urandom()};
            tick();
        end
        check("rand_budget", acc_cnt >= 16, 1'b1);
        invalid = 1'b0; en = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("rand_drained", sent.size(), 0);
        check("rand_rx_cnt", rx_cnt, 0);

        // Single-phit flits: one phit per cycle, last tracks new.
        invalid1 = 1'b1; en1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            indata1 = (i % 2 == 0) ? 16'hA5A5 : 16'h5A5A;
            #1;
            check("f1_rdy", inready1, 1'b1);
            check("f1_last", last1, new_phit1);
            if (i == 0) begin
                check("f1_new0", new_phit1, 1'b0);
            end else begin
                check("f1_new", new_phit1, 1'b1);
                check("f1_out", outdata1, prev1);
            end
            prev1 = indata1;
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/phit_send.md
PHIT_SEND -- requirements
Module: phit_send

Interface
REQ-001 SHALL have parameter flit_size, default 1, flit length in phits (>=1).
REQ-002 SHALL have parameter floorplusone_log2_flit_size, default 1, phit pointer width, floor(log2(flit_size))+1.
REQ-003 SHALL have parameter phit_size, default 16, phit width in bits.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port rs, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port indata, input, flit_size*phit_size, flit to transmit; phit k occupies bits [(k+1)*phit_size-1 : k*phit_size].
REQ-007 SHALL have port invalid, input, 1, indata holds a flit offered for transmission.
REQ-008 SHALL have port inready, output, 1, block accepts indata this cycle.
REQ-009 SHALL have port outdata, output, phit_size, current phit on the link.
REQ-010 SHALL have port new, output, 1, outdata holds a valid phit; drives the receiver's new input.
REQ-011 SHALL have port en, input, 1, link enable; a phit is consumed in any cycle with new & en.
REQ-012 SHALL have port last, output, 1, outdata is the final phit of the current flit (new & pointer==flit_size-1).

Function
REQ-013 SHALL accept a flit (load) exactly in cycles where invalid & inready; indata is registered in full at that edge.
REQ-014 SHALL keep two states: IDLE (new=0) and SEND (new=1); load moves IDLE->SEND, consumption of the last phit with no load moves SEND->IDLE.
REQ-015 SHALL transmit phits in order 0,1,...,flit_size-1 (phit 0 = low bits first, final phit = high bits), matching the receiver's assembly order.
REQ-016 SHALL present phit 0 on outdata with new=1 in the cycle after load (latency 1), pointer=0.
REQ-017 SHALL, on new & en with pointer<flit_size-1, advance pointer by 1 and present the next phit on the following cycle.
REQ-018 SHALL hold outdata, pointer and new unchanged in any cycle where en=0.
REQ-019 SHALL drive inready = (state==IDLE) | (en & last), combinationally.
REQ-020 SHALL, on load coinciding with consumption of the last phit, present phit 0 of the new flit next cycle with new=1 and no idle gap (back-to-back flits).
REQ-021 SHALL ignore indata and invalid whenever inready=0; the held flit is never overwritten mid-transmission.
REQ-022 SHALL, for flit_size=1, send each flit as a single phit with last=new at all times and inready = ~new | en.
REQ-023 SHALL drive outdata to 0 while in IDLE.
REQ-024 SHALL wrap pointer from flit_size-1 to 0 on consumption of the last phit; pointer never exceeds flit_size-1.

Reset
REQ-025 SHALL, when rs=1 at a rising edge, set state=IDLE, pointer=0, new=0, last=0, outdata=0 and clear the flit register.
REQ-026 SHALL give rs priority over load and consumption; a flit in transmission is discarded and an offered flit with invalid=1 is not accepted on a reset edge.
REQ-027 SHALL present inready=1 in the first cycle after reset release.

Verification (flit_size=4, phit_size=16 unless stated)
REQ-028 SHALL verify basic send: load indata=0x4444_3333_2222_1111, en=1 -> outdata 0x1111,0x2222,0x3333,0x4444 on 4 consecutive cycles, new=1 throughout, last=1 only on 0x4444, then new=0, outdata=0.
REQ-029 SHALL verify stall: en=0 for 3 cycles while outdata=0x2222 -> outdata, new and pointer held; sequence resumes with 0x3333 once en=1; inready=0 throughout.
REQ-030 SHALL verify back-to-back: second flit 0x8888_7777_6666_5555 held with invalid=1 -> accepted only in the 0x4444 cycle; 0x5555 follows 0x4444 with no gap; 8 phits in 8 cycles.
REQ-031 SHALL verify reset mid-flit: rs=1 while outdata=0x3333 with invalid=1 -> next cycle new=0, outdata=0, inready=1; offered flit not sent.
REQ-032 SHALL verify end-to-end with the phit receiver (same parameters, shared en): 16 random flits with random en gaps -> receiver valid pulses once per flit with outdata equal to each sent indata, in order.
REQ-033 SHALL verify flit_size=1: continuous invalid=1, en=1 with values 0xA5A5, 0x5A5A -> one phit per cycle, last=new, inready=1 every cycle.
